// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - alarm scheduler keeping mtimecmp at the earliest armed deadline
module timer_sched #(
  parameter int unsigned               NumSlots     = 4,
  parameter int unsigned               DataWidth    = 32,
  parameter int unsigned               AddressWidth = 32,
  parameter logic [AddressWidth-1:0]   TimerBase    = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    host_req_i,
  input  logic                    host_we_i,
  input  logic [AddressWidth-1:0] host_addr_i,
  input  logic [3:0]              host_be_i,
  input  logic [DataWidth-1:0]    host_wdata_i,
  output logic                    host_rvalid_o,
  output logic                    host_err_o,
  output logic [DataWidth-1:0]    host_rdata_o,
  output logic                    tmr_req_o,
  output logic                    tmr_we_o,
  output logic [AddressWidth-1:0] tmr_addr_o,
  output logic [3:0]              tmr_be_o,
  output logic [DataWidth-1:0]    tmr_wdata_o,
  input  logic                    tmr_rvalid_i,
  input  logic                    tmr_intr_i,
  input  logic [DataWidth-1:0]    tmr_rdata_i,
  output logic                    irq_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SCAN, ST_PROG, ST_RD_HI, ST_RD_LO, ST_RD_HI2, ST_EVAL
  } state_e;

  localparam logic [AddressWidth-1:0] AddrMtimeLo = TimerBase + AddressWidth'(4'h0);
  localparam logic [AddressWidth-1:0] AddrMtimeHi = TimerBase + AddressWidth'(4'h4);
  localparam logic [AddressWidth-1:0] AddrCmpLo   = TimerBase + AddressWidth'(4'h8);
  localparam logic [AddressWidth-1:0] AddrCmpHi   = TimerBase + AddressWidth'(4'hC);

  state_e state_q, state_d;

  // Sequencing state
  logic                wait_q;
  logic [1:0]          prog_step_q;
  logic [2:0]          scan_idx_q;
  logic [63:0]         min_q;
  logic [31:0]         hi1_q;
  logic [31:0]         lo_q;

  // Host-visible alarm state
  logic [63:0]         dl_q [NumSlots];
  logic [NumSlots-1:0] armed_q;
  logic [NumSlots-1:0] expired_q;
  logic                dirty_q;

  // Host decode results
  logic [4:0]          word;
  logic [2:0]          slot;
  logic                slot_ok, sts_sel, arm_sel, addr_ok, host_wr;
  logic [NumSlots-1:0] dlo_wr, dhi_wr;
  logic [31:0]         rd_val;
  logic [31:0]         sts_mask;
  logic [NumSlots-1:0] sts_clr;

  logic                acc_state, acc_done, scan_last;
  logic [63:0]         cur_dl;
  logic                cur_arm;
  logic [63:0]         snap;
  logic [NumSlots-1:0] eval_set;

  logic                unused_addr;
  assign unused_addr = ^{host_addr_i[AddressWidth-1:7], host_addr_i[1:0]};

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  assign acc_state = (state_q == ST_PROG) || (state_q == ST_RD_HI) ||
                     (state_q == ST_RD_LO) || (state_q == ST_RD_HI2);
  assign acc_done  = acc_state && wait_q && tmr_rvalid_i;
  assign scan_last = (scan_idx_q == 3'(NumSlots - 1));
  assign snap      = {hi1_q, lo_q};
  assign irq_o     = |expired_q;
  assign tmr_be_o  = 4'hF;

  // Host address decode, per-slot write strobes and read mux
  always_comb begin
    word     = host_addr_i[6:2];
    slot     = word[3:1];
    slot_ok  = !word[4] && (32'(slot) < NumSlots);
    sts_sel  = (word == 5'h10);
    arm_sel  = (word == 5'h11);
    addr_ok  = slot_ok || sts_sel || arm_sel;
    host_wr  = host_req_i && host_we_i;
    dlo_wr   = '0;
    dhi_wr   = '0;
    rd_val   = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (slot_ok && (slot == 3'(i))) begin
        dlo_wr[i] = host_wr && !word[0];
        dhi_wr[i] = host_wr && word[0];
        rd_val    = word[0] ? dl_q[i][63:32] : dl_q[i][31:0];
      end
    end
    if (sts_sel) rd_val = 32'(expired_q);
    if (arm_sel) rd_val = 32'(armed_q);
    sts_mask = be_merge(32'h0, host_wdata_i, host_be_i);
    sts_clr  = (host_wr && sts_sel) ? sts_mask[NumSlots-1:0] : '0;
  end

  // Slot currently visited by the scan
  always_comb begin
    cur_dl  = '0;
    cur_arm = 1'b0;
    for (int i = 0; i < NumSlots; i++) begin
      if (scan_idx_q == 3'(i)) begin
        cur_dl  = dl_q[i];
        cur_arm = armed_q[i];
      end
    end
  end

  // Due slots in EVAL; a host write to the same slot takes precedence
  always_comb begin
    eval_set = '0;
    for (int i = 0; i < NumSlots; i++) begin
      eval_set[i] = (state_q == ST_EVAL) && armed_q[i] && (dl_q[i] <= snap) &&
                    !dlo_wr[i] && !dhi_wr[i];
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic; a pending rescan beats a timer interrupt
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dirty_q)         state_d = ST_SCAN;
        else if (tmr_intr_i) state_d = ST_RD_HI;
      end
      ST_SCAN:   if (scan_last) state_d = ST_PROG;
      ST_PROG:   if (acc_done && (prog_step_q == 2'd2)) state_d = ST_IDLE;
      ST_RD_HI:  if (acc_done) state_d = ST_RD_LO;
      ST_RD_LO:  if (acc_done) state_d = ST_RD_HI2;
      ST_RD_HI2: if (acc_done) state_d = (tmr_rdata_i != hi1_q) ? ST_RD_LO : ST_EVAL;
      ST_EVAL:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: a one-cycle timer request whenever no access is outstanding
  always_comb begin
    tmr_req_o   = acc_state && !wait_q;
    tmr_we_o    = 1'b0;
    tmr_addr_o  = '0;
    tmr_wdata_o = '0;
    if (tmr_req_o) begin
      case (state_q)
        ST_PROG: begin
          tmr_we_o = 1'b1;
          // Park hi at all-ones first so the lo update cannot cause a false match
          case (prog_step_q)
            2'd0:    begin tmr_addr_o = AddrCmpHi; tmr_wdata_o = 32'hFFFF_FFFF; end
            2'd1:    begin tmr_addr_o = AddrCmpLo; tmr_wdata_o = min_q[31:0];   end
            default: begin tmr_addr_o = AddrCmpHi; tmr_wdata_o = min_q[63:32];  end
          endcase
        end
        ST_RD_LO: tmr_addr_o = AddrMtimeLo;
        default:  tmr_addr_o = AddrMtimeHi;
      endcase
    end
  end

  // Scan minimum, PROG step, access handshake and mtime capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q      <= 1'b0;
      prog_step_q <= '0;
      scan_idx_q  <= '0;
      min_q       <= '1;
      hi1_q       <= '0;
      lo_q        <= '0;
    end else begin
      if (!acc_state)        wait_q <= 1'b0;
      else if (!wait_q)      wait_q <= 1'b1;
      else if (tmr_rvalid_i) wait_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          prog_step_q <= '0;
          if (dirty_q) begin
            scan_idx_q <= '0;
            min_q      <= '1;
          end
        end
        ST_SCAN: begin
          scan_idx_q <= scan_idx_q + 3'd1;
          // Strict compare keeps the lower index on ties
          if (cur_arm && (cur_dl < min_q)) min_q <= cur_dl;
        end
        ST_PROG:   if (acc_done) prog_step_q <= prog_step_q + 2'd1;
        ST_RD_HI:  if (acc_done) hi1_q <= tmr_rdata_i;
        ST_RD_LO:  if (acc_done) lo_q  <= tmr_rdata_i;
        ST_RD_HI2: if (acc_done) hi1_q <= tmr_rdata_i;
        default: ;
      endcase
    end
  end

  // Deadlines, armed/expired masks and the rescan request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSlots; i++) dl_q[i] <= '0;
      armed_q   <= '0;
      expired_q <= '0;
      dirty_q   <= 1'b1;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (dlo_wr[i]) dl_q[i][31:0]  <= be_merge(dl_q[i][31:0],  host_wdata_i, host_be_i);
        if (dhi_wr[i]) dl_q[i][63:32] <= be_merge(dl_q[i][63:32], host_wdata_i, host_be_i);
        if (dlo_wr[i])        armed_q[i] <= 1'b0;
        else if (dhi_wr[i])   armed_q[i] <= 1'b1;
        else if (eval_set[i]) armed_q[i] <= 1'b0;
      end
      // Hardware set wins over a simultaneous write-1-to-clear
      expired_q <= (expired_q & ~sts_clr) | eval_set;
      if ((|dlo_wr) || (|dhi_wr) || (|eval_set)) dirty_q <= 1'b1;
      else if (state_q == ST_IDLE)                dirty_q <= 1'b0;
    end
  end

  // Host response, one cycle after each request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      host_rvalid_o <= 1'b0;
      host_err_o    <= 1'b0;
      host_rdata_o  <= '0;
    end else begin
      host_rvalid_o <= host_req_i;
      if (host_req_i) begin
        host_err_o   <= !addr_ok;
        host_rdata_o <= (!addr_ok || host_we_i) ? '0 : rd_val;
      end
    end
  end

endmodule

// File: tb/tb_timer_sched.sv
// tb/tb_timer_sched.sv - randomized self-checking bench for timer_sched with a timer model
module tb_timer_sched;
  localparam int NS = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        host_req_i = 1'b0, host_we_i = 1'b0;
  logic [31:0] host_addr_i = '0;
  logic [3:0]  host_be_i = 4'hF;
  logic [31:0] host_wdata_i = '0;
  logic        host_rvalid_o, host_err_o;
  logic [31:0] host_rdata_o;
  logic        tmr_req_o, tmr_we_o;
  logic [31:0] tmr_addr_o;
  logic [3:0]  tmr_be_o;
  logic [31:0] tmr_wdata_o;
  logic        tmr_rvalid_i;
  logic        tmr_intr_i;
  logic [31:0] tmr_rdata_i;
  logic        irq_o;

  always #5 clk_i = ~clk_i;

  timer_sched #(.NumSlots(NS), .DataWidth(32), .AddressWidth(32), .TimerBase(32'h0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_err_o(host_err_o), .host_rdata_o(host_rdata_o),
    .tmr_req_o(tmr_req_o), .tmr_we_o(tmr_we_o), .tmr_addr_o(tmr_addr_o),
    .tmr_be_o(tmr_be_o), .tmr_wdata_o(tmr_wdata_o),
    .tmr_rvalid_i(tmr_rvalid_i), .tmr_intr_i(tmr_intr_i), .tmr_rdata_i(tmr_rdata_i),
    .irq_o(irq_o)
  );

  // Timer slave model
  logic [63:0] mtime = '0;
  logic [63:0] mtimecmp;
  logic [63:0] mt_req_val = '0;
  logic        mt_req_roll = 1'b0;
  int          mt_req_seq = 0, mt_ack_seq = 0;
  logic        roll_armed = 1'b0;
  int          lo_reads = 0, proto_err = 0, wr_count = 0;
  logic [35:0] wlog [1024];

  assign tmr_intr_i = (mtime >= mtimecmp);

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtimecmp     <= '0;
      tmr_rvalid_i <= 1'b0;
      tmr_rdata_i  <= '0;
    end else begin
      tmr_rvalid_i <= tmr_req_o;
      if (mt_req_seq != mt_ack_seq) begin
        mtime      <= mt_req_val;
        roll_armed <= mt_req_roll;
        mt_ack_seq <= mt_req_seq;
      end
      if (tmr_req_o) begin
        if (tmr_rvalid_i) proto_err <= proto_err + 1;
        if (tmr_we_o) begin
          if (tmr_addr_o[3:0] == 4'h8) mtimecmp[31:0]  <= tmr_wdata_o;
          if (tmr_addr_o[3:0] == 4'hC) mtimecmp[63:32] <= tmr_wdata_o;
          wlog[wr_count % 1024] <= {tmr_addr_o[3:0], tmr_wdata_o};
          wr_count <= wr_count + 1;
        end else if (tmr_addr_o[3:0] == 4'h0) begin
          tmr_rdata_i <= mtime[31:0];
          lo_reads    <= lo_reads + 1;
        end else begin
          tmr_rdata_i <= mtime[63:32];
          if (roll_armed) begin
            mtime      <= {mtime[63:32] + 32'd1, 32'h5};
            roll_armed <= 1'b0;
          end
        end
      end
    end
  end

  // Reference model of the scheduler's architectural state
  logic [63:0]   m_dl [NS];
  logic [NS-1:0] m_arm = '0, m_exp = '0;
  logic [63:0]   m_now = '0;

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_target();
    logic [63:0] t;
    t = '1;
    for (int i = 0; i < NS; i++) if (m_arm[i] && m_dl[i] < t) t = m_dl[i];
    return t;
  endfunction

  task automatic m_expire(input logic [63:0] t);
    for (int i = 0; i < NS; i++) begin
      if (m_arm[i] && m_dl[i] <= t) begin
        m_exp[i] = 1'b1;
        m_arm[i] = 1'b0;
      end
    end
  endtask

  task automatic host_wr(input logic [31:0] a, input logic [31:0] d);
    int s;
    @(negedge clk_i);
    host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = a; host_wdata_i = d; host_be_i = 4'hF;
    @(negedge clk_i);
    host_req_i = 1'b0; host_we_i = 1'b0;
    s = int'(a[5:3]);
    if (a < 32'h40 && s < NS) begin
      if (!a[2]) begin m_dl[s][31:0]  = d; m_arm[s] = 1'b0; end
      else       begin m_dl[s][63:32] = d; m_arm[s] = 1'b1; end
    end else if (a == 32'h40) begin
      m_exp = m_exp & ~d[NS-1:0];
    end
  endtask

  task automatic host_rd(input logic [31:0] a, output logic [31:0] d,
                         output logic e, output logic v);
    @(negedge clk_i);
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = a;
    @(negedge clk_i);
    d = host_rdata_o; e = host_err_o; v = host_rvalid_o;
    host_req_i = 1'b0;
  endtask

  task automatic arm(input int s, input logic [63:0] v);
    host_wr(32'(8 * s), v[31:0]);
    host_wr(32'(8 * s + 4), v[63:32]);
  endtask

  task automatic set_mtime(input logic [63:0] v, input logic roll);
    @(negedge clk_i);
    mt_req_val = v; mt_req_roll = roll; mt_req_seq++;
    @(negedge clk_i);
  endtask

  task automatic settle();
    repeat (60) @(negedge clk_i);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] d; logic e, v;
    host_rd(32'h40, d, e, v);
    check({tag, "_status"}, d, 64'(m_exp));
    host_rd(32'h44, d, e, v);
    check({tag, "_armed"}, d, 64'(m_arm));
    check({tag, "_irq"}, irq_o, |m_exp);
    check({tag, "_cmp"}, mtimecmp, m_target());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d; logic e, v;
    int w0, l0, s, op;
    bit seen;
    for (int i = 0; i < NS; i++) m_dl[i] = '0;

    repeat (3) @(negedge clk_i);
    check("rst_req", tmr_req_o, 0);
    check("rst_be", tmr_be_o, 4'hF);
    check("rst_rvalid", host_rvalid_o, 0);
    check("rst_irq", irq_o, 0);
    rst_ni = 1'b1;
    settle();
    check("boot_wr0", wlog[0], {4'hC, 32'hFFFF_FFFF});
    check("boot_wr1", wlog[1], {4'h8, 32'hFFFF_FFFF});
    check("boot_wr2", wlog[2], {4'hC, 32'hFFFF_FFFF});
    check("boot_wrcnt", wr_count, 3);
    check("boot_irq", irq_o, 0);

    // Earliest of two deadlines is programmed, then the next one
    arm(2, 64'h100);
    arm(0, 64'h200);
    settle();
    check("two_cmp", mtimecmp, 64'h100);
    set_mtime(64'h100, 1'b0); m_now = 64'h100; m_expire(m_now);
    settle();
    host_rd(32'h40, d, e, v);
    check("two_status", d, 32'h4);
    check("two_irq", irq_o, 1);
    check("two_cmp2", mtimecmp, 64'h200);

    // Two slots sharing a deadline expire together
    host_wr(32'h40, 32'h4);
    host_wr(32'h00, 32'h0);
    set_mtime(64'h0, 1'b0); m_now = 0;
    arm(1, 64'h50);
    arm(3, 64'h50);
    settle();
    check("tie_cmp", mtimecmp, 64'h50);
    set_mtime(64'h60, 1'b0); m_now = 64'h60; m_expire(m_now);
    settle();
    host_rd(32'h40, d, e, v);
    check("tie_status", d, 32'hA);
    host_rd(32'h44, d, e, v);
    check("tie_armed", d, 32'h0);
    host_wr(32'h40, 32'hA);
    check("tie_irq_clr", irq_o, 0);

    // mtime hi rolls between the two hi reads
    arm(0, 64'h0_FFFF_FFF0);
    arm(1, 64'h1_0000_0004);
    settle();
    check("roll_cmp", mtimecmp, 64'h0_FFFF_FFF0);
    l0 = lo_reads;
    set_mtime(64'h0_FFFF_FFF8, 1'b1); m_now = 64'h1_0000_0005; m_expire(m_now);
    settle();
    check("roll_lo_reads", lo_reads - l0, 2);
    check("roll_mtime", mtime, 64'h1_0000_0005);
    check_all("roll");

    // Disarm during PROG completes the sequence, then rescans
    host_wr(32'h40, 32'h3);
    arm(2, 64'h2_0000_0000);
    arm(3, 64'h3_0000_0000);
    settle();
    check("prog_cmp0", mtimecmp, 64'h2_0000_0000);
    w0 = wr_count;
    host_wr(32'h0C, 32'h5);
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk_i);
      if (tmr_req_o && tmr_we_o) seen = 1;
    end
    check("prog_seen", seen, 1);
    host_wr(32'h10, 32'h0);
    settle();
    check("prog_wrcnt", wr_count - w0, 6);
    check("prog_cmp", mtimecmp, 64'h3_0000_0000);
    check_all("prog");

    // Decode errors and response timing
    host_rd(32'h48, d, e, v);
    check("err48_v", v, 1); check("err48_e", e, 1); check("err48_d", d, 0);
    host_rd(32'h28, d, e, v);
    check("errdlo5_v", v, 1); check("errdlo5_e", e, 1); check("errdlo5_d", d, 0);
    @(negedge clk_i);
    check("rvalid_drop", host_rvalid_o, 0);
    host_rd(32'h44, d, e, v);
    check("armed_ok_e", e, 0);

    // Randomized arm/disarm/clear and time advance
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 3; k++) begin
        op = $urandom_range(0, 3);
        s  = $urandom_range(0, NS - 1);
        if (op <= 1)      arm(s, m_now + 64'($urandom_range(1, 300)));
        else if (op == 2) host_wr(32'(8 * s), $urandom);
        else              host_wr(32'h40, 32'($urandom_range(0, 15)));
      end
      settle();
      check("rnd_cmp_pre", mtimecmp, m_target());
      m_now = m_now + 64'($urandom_range(0, 250));
      set_mtime(m_now, 1'b0);
      m_expire(m_now);
      settle();
      check_all("rnd");
      s = $urandom_range(0, NS - 1);
      host_rd(32'(8 * s + 4), d, e, v);
      check("rnd_dhi", d, m_dl[s][63:32]);
    end

    check("proto", proto_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
